vga_pixel_display: RTL and testbench



---
 rtl/vga_pixel_display.sv | 156 +++++++++++++++
 tb/tb_vga_pixel_display.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_display.sv
// Pixel-write sink with a 160x120x12 framebuffer, scanned out as 640x480@60 VGA (4x replication).
// Optional dim grid on black pixels: define VGA_GRID_OVERLAY_EN.
module vga_pixel_display #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic        in_we,
  input  logic [11:0] in_rgb,
  input  logic        clear,
  output logic        clear_busy,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int AW       = $clog2(FB_DEPTH);
  localparam logic [AW-1:0] FB_W_A    = AW'(FB_W);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_addr, clr_addr_nxt;
  logic [9:0]    h_cnt, v_cnt;

  // Raster counters
  always_ff @(posedge clk_25) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 10'(H_TOT - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(V_TOT - 1)) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  logic hs_now, vs_now, vis_now, fs_now;
  assign hs_now  = !((h_cnt >= 10'(H_VIS + H_FP)) && (h_cnt < 10'(H_VIS + H_FP + H_SYNC)));
  assign vs_now  = !((v_cnt >= 10'(V_VIS + V_FP)) && (v_cnt < 10'(V_VIS + V_FP + V_SYNC)));
  assign vis_now = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
  assign fs_now  = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  logic [AW-1:0] rd_addr, in_addr, wr_addr;
  logic [11:0]   wr_data, rd_data;
  logic          wr_en, in_range;

  assign rd_addr  = AW'(v_cnt >> SCALE_SHIFT) * FB_W_A + AW'(h_cnt >> SCALE_SHIFT);
  assign in_addr  = AW'(in_y) * FB_W_A + AW'(in_x);
  assign in_range = (in_x < 8'(FB_W)) && (in_y < 8'(FB_H));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    wr_en        = 1'b0;
    wr_addr      = in_addr;
    wr_data      = in_rgb;
    case (state)
      IDLE: begin
        wr_en = in_we && in_range;
        if (clear) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      CLEAR: begin
        wr_en        = 1'b1;
        wr_addr      = clr_addr;
        wr_data      = 12'h000;
        clr_addr_nxt = clr_addr + AW'(1);
        if (clr_addr == LAST_ADDR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  assign clear_busy = (state == CLEAR);

  // NOTE: the framebuffer has no reset so it maps onto block RAM; reading the old
  // word before the non-blocking write lands gives read-before-write on collisions.
  logic [11:0] fb [FB_DEPTH];
  always_ff @(posedge clk_25) begin
    if (wr_en && !rst) fb[wr_addr] <= wr_data;
    rd_data <= fb[rd_addr];
  end

  logic [11:0] pix;
`ifdef VGA_GRID_OVERLAY_EN
  logic grid_now, grid_d1;
  assign grid_now = (((h_cnt >> SCALE_SHIFT) % 10'd20) == 10'd0) ||
                    (((v_cnt >> SCALE_SHIFT) % 10'd20) == 10'd0);
  always_ff @(posedge clk_25) grid_d1 <= grid_now;
  assign pix = (grid_d1 && (rd_data == 12'h000)) ? 12'h444 : rd_data;
`else
  assign pix = rd_data;
`endif

  // Sync/visible/frame flags ride alongside the RAM read so pins stay aligned.
  logic        hs_d1, vs_d1, vis_d1, fs_d1;
  logic [11:0] rgb_q;
  always_ff @(posedge clk_25) begin
    if (rst) begin
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      vis_d1      <= 1'b0;
      fs_d1       <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
      rgb_q       <= '0;
    end else begin
      hs_d1       <= hs_now;
      vs_d1       <= vs_now;
      vis_d1      <= vis_now;
      fs_d1       <= fs_now;
      vga_hs      <= hs_d1;
      vga_vs      <= vs_d1;
      frame_start <= fs_d1;
      rgb_q       <= vis_d1 ? pix : 12'h000;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_pixel_display.sv
// Self-checking bench for vga_pixel_display on a scaled-down raster (16x12 framebuffer,
// 80x55 timing) so whole frames fit in a short run; every pin is compared every cycle.
module tb_vga_pixel_display;

  localparam int FB_W = 16, FB_H = 12, SS = 2, REP = 4;
  localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 48, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int DEPTH = FB_W * FB_H;

  logic        clk_25 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_x = '0, in_y = '0;
  logic        in_we = 1'b0;
  logic [11:0] in_rgb = '0;
  logic        clear = 1'b0;
  logic        clear_busy, vga_hs, vga_vs, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;

  vga_pixel_display #(
    .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(SS),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk_25(clk_25), .rst(rst), .in_x(in_x), .in_y(in_y), .in_we(in_we),
    .in_rgb(in_rgb), .clear(clear), .clear_busy(clear_busy), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    logic hs;
    logic vs;
    logic fs;
    int   rgb;  // -1: framebuffer word never written, colour not checked
  } pins_t;

  int    mem [DEPTH];
  pins_t exp_q [$];
  int    t, clear_left, clr_idx;
  int    vectors, miscompares;
  bit    meas;
  int    hs_low, vs_low, fs_cnt, busy_cnt;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d after reset)", tag, obs, exp, t);
    end
  endtask

  // Reference pin values for the raster position at cycle t, from current model memory.
  function automatic pins_t expected_now();
    pins_t e;
    int c, h, v, lx, ly, val;
    c    = t % FRAME;
    h    = c % H_TOT;
    v    = c / H_TOT;
    e.hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
    e.vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
    e.fs = (c == 0);
    e.rgb = 0;
    if (h < H_VIS && v < V_VIS) begin
      lx  = h / REP;
      ly  = v / REP;
      val = mem[ly * FB_W + lx];
`ifdef VGA_GRID_OVERLAY_EN
      if (val == 0 && (lx % 20 == 0 || ly % 20 == 0)) val = 'h444;
`endif
      e.rgb = val;
    end
    return e;
  endfunction

  // Effect of one non-reset clock edge on the model.
  task automatic model_edge();
    if (clear_left > 0) begin
      mem[clr_idx] = 0;
      clr_idx++;
      clear_left--;
    end else begin
      if (in_we && in_x < FB_W && in_y < FB_H) mem[int'(in_y) * FB_W + int'(in_x)] = int'(in_rgb);
      if (clear) begin
        clear_left = DEPTH;
        clr_idx    = 0;
      end
    end
    t++;
  endtask

  task automatic step();
    pins_t p;
    p = exp_q.pop_front();
    check("hs", vga_hs, p.hs);
    check("vs", vga_vs, p.vs);
    check("frame_start", frame_start, p.fs);
    if (p.rgb >= 0) check("rgb", {vga_r, vga_g, vga_b}, p.rgb[11:0]);
    check("clear_busy", clear_busy, clear_left > 0);
    if (meas) begin
      hs_low += int'(!vga_hs);
      vs_low += int'(!vga_vs);
      fs_cnt += int'(frame_start);
    end
    busy_cnt += int'(clear_busy);
    exp_q.push_back(expected_now());
    @(posedge clk_25);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    pins_t r;
    rst   = 1'b1;
    in_we = 1'b0;
    clear = 1'b0;
    @(posedge clk_25);
    #1;
    rst        = 1'b0;
    t          = 0;
    clear_left = 0;
    r.hs = 1'b1; r.vs = 1'b1; r.fs = 1'b0; r.rgb = 0;
    exp_q.delete();
    exp_q.push_back(r);
    exp_q.push_back(r);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic write_px(int x, int y, int rgb);
    in_x   = 8'(x);
    in_y   = 8'(y);
    in_rgb = 12'(rgb);
    in_we  = 1'b1;
    step();
    in_we  = 1'b0;
  endtask

  task automatic fill(logic [11:0] rgb);
    in_we  = 1'b1;
    in_rgb = rgb;
    for (int a = 0; a < DEPTH; a++) begin
      in_x = 8'(a % FB_W);
      in_y = 8'(a / FB_W);
      step();
    end
    in_we = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic run_to(int h, int v);
    for (int i = 0; i < FRAME && (t % FRAME) != v * H_TOT + h; i++) step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = -1;

    // One idle frame: sync widths, frame_start rate, blanking colour
    do_reset();
    run(2);
    hs_low = 0; vs_low = 0; fs_cnt = 0;
    meas = 1'b1;
    run(FRAME);
    meas = 1'b0;
    check("hs_low_per_frame", hs_low, H_SYNC * V_TOT);
    check("vs_low_per_frame", vs_low, V_SYNC * H_TOT);
    check("frame_start_count", fs_cnt, 1);

    // Clear to a known state
    busy_cnt = 0;
    pulse_clear();
    run(DEPTH + 4);
    check("clear_busy_len_1", busy_cnt, DEPTH);

    // Single pixel and its neighbours
    write_px(5, 3, 'hF0A);
    run(FRAME);

    // Random writes, some out of range
    for (int i = 0; i < 600; i++) begin
      in_we  = 1'($urandom_range(0, 1));
      in_x   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, FB_W + 1));
      in_y   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, FB_H + 1));
      in_rgb = 12'($urandom);
      step();
    end
    in_we = 1'b0;
    run(FRAME);

    // Out-of-range coordinates are dropped
    write_px(FB_W, 0, 'h123);
    write_px(160, 1, 'h234);
    write_px(0, FB_H, 'h345);
    write_px(1, 120, 'h456);
    write_px(2, 128, 'h567);
    write_px(255, 255, 'h678);
    run(FRAME);

    // Fill white, clear while hammering writes and clear requests
    fill(12'hFFF);
    busy_cnt = 0;
    pulse_clear();
    for (int i = 0; i < DEPTH; i++) begin
      in_we  = 1'b1;
      in_x   = 8'($urandom_range(0, FB_W - 1));
      in_y   = 8'($urandom_range(0, FB_H - 1));
      in_rgb = 12'($urandom);
      clear  = 1'($urandom_range(0, 1));
      step();
    end
    in_we = 1'b0;
    clear = 1'b0;
    run(2);
    check("clear_busy_len_2", busy_cnt, DEPTH);
    run(FRAME);

    // Reset part-way through a clear leaves a partially cleared screen
    fill(12'hFFF);
    pulse_clear();
    run(70);
    do_reset();
    run(FRAME + 2);

    // Write the word being read in the same cycle: old colour now, new colour next frame
    run_to(8, 4);
    write_px(2, 1, 'hABC);
    run(FRAME + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
